// File: rtl/div_ctrl_pkg.sv
// Shared constants for the iterative divider controller: FSM encoding and
// the iteration count of the restoring divide.
package div_ctrl_pkg;
   localparam int DIV_ITERS = 32;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;
endpackage

// File: rtl/div_ctrl_if.sv
// EX-stage <-> divider bundle: the divide request going in, stall and HI/LO
// write-back coming out.
interface div_ctrl_if #(
   parameter int WIDTH = 32
);
   logic             startE;
   logic             signedE;
   logic [WIDTH-1:0] srcaE;
   logic [WIDTH-1:0] srcbE;
   logic             flushE;
   logic             div_stall;
   logic             busy;
   logic             hilo_we;
   logic [WIDTH-1:0] hi_o;
   logic [WIDTH-1:0] lo_o;

   modport master (
      output startE, signedE, srcaE, srcbE, flushE,
      input  div_stall, busy, hilo_we, hi_o, lo_o
   );

   modport slave (
      input  startE, signedE, srcaE, srcbE, flushE,
      output div_stall, busy, hilo_we, hi_o, lo_o
   );
endinterface

// File: rtl/div_ctrl_div_step.sv
// One combinational restoring-division iteration on {rem,quo} against an
// unsigned divisor.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH-1:0] dvs,
   output logic [WIDTH-1:0] rem_nx,
   output logic [WIDTH-1:0] quo_nx
);
   logic [WIDTH:0] sh;
   logic [WIDTH:0] diff;

   // One extra bit so the shifted remainder never overflows before the trial subtract
   assign sh     = {rem, quo[WIDTH-1]};
   assign diff   = sh - {1'b0, dvs};
   assign rem_nx = diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0];
   assign quo_nx = {quo[WIDTH-2:0], ~diff[WIDTH]};
endmodule

// File: rtl/div_ctrl.sv
// DIV/DIVU sequencer: stalls the front end for WIDTH restoring iterations,
// then writes sign-corrected HI/LO once.
module div_ctrl
   import div_ctrl_pkg::*;
#(
   parameter int WIDTH = DIV_ITERS
) (
   input logic      clk,
   input logic      rst_n,
   div_ctrl_if.slave bus
);
   localparam int CW = $clog2(WIDTH) + 1;

   logic [1:0]       state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] rem, quo, dvs, a_raw;
   logic [WIDTH-1:0] rem_nx, quo_nx;
   logic [WIDTH-1:0] hi_q, lo_q;
   logic             q_neg, r_neg, dz;
   logic             a_neg, b_neg, last;
   logic [WIDTH-1:0] a_mag, b_mag, q_fix, r_fix;

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem    (rem),
      .quo    (quo),
      .dvs    (dvs),
      .rem_nx (rem_nx),
      .quo_nx (quo_nx)
   );

   assign a_neg = bus.signedE & bus.srcaE[WIDTH-1];
   assign b_neg = bus.signedE & bus.srcbE[WIDTH-1];
   assign a_mag = a_neg ? -bus.srcaE : bus.srcaE;
   assign b_mag = b_neg ? -bus.srcbE : bus.srcbE;
   assign last  = (cnt == CW'(WIDTH - 1));

   // Fix-up is applied to the final step's output so HI/LO are ready in DONE
   assign q_fix = q_neg ? -quo_nx : quo_nx;
   assign r_fix = r_neg ? -rem_nx : rem_nx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         rem   <= '0;
         quo   <= '0;
         dvs   <= '0;
         a_raw <= '0;
         q_neg <= 1'b0;
         r_neg <= 1'b0;
         dz    <= 1'b0;
         hi_q  <= '0;
         lo_q  <= '0;
      end else begin
         case (state)
            IDLE: if (bus.startE && !bus.flushE) begin
               quo   <= a_mag;
               dvs   <= b_mag;
               rem   <= '0;
               cnt   <= '0;
               a_raw <= bus.srcaE;
               q_neg <= a_neg ^ b_neg;
               r_neg <= a_neg;
               dz    <= (bus.srcbE == '0);
               state <= BUSY;
            end
            BUSY: if (bus.flushE) begin
               state <= IDLE;
            end else begin
               rem <= rem_nx;
               quo <= quo_nx;
               cnt <= cnt + 1'b1;
               if (last) begin
                  state <= DONE;
                  hi_q  <= dz ? a_raw : r_fix;
                  lo_q  <= dz ? '1    : q_fix;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy      = (state == BUSY);
   assign bus.div_stall = (((state == IDLE) && bus.startE) || (state == BUSY)) && !bus.flushE;
   assign bus.hilo_we   = (state == DONE) && !bus.flushE;
   assign bus.hi_o      = hi_q;
   assign bus.lo_o      = lo_q;
endmodule

// File: tb/tb_div_ctrl.sv
// Scoreboard bench for div_ctrl: directed divides push expected HI/LO and
// write cycle; a monitor pops on every hilo_we.
module tb_div_ctrl;
   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          cyc;
   } exp_t;

   logic clk;
   logic rst_n;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   exp_t mon_e;

   div_ctrl_if #(.WIDTH(32)) bus ();

   div_ctrl #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && bus.hilo_we) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_we cycle=%0d hi=%h lo=%h", cyc, bus.hi_o, bus.lo_o);
         end else begin
            mon_e = sb.pop_front();
            check("lo_o", bus.lo_o, mon_e.lo);
            check("hi_o", bus.hi_o, mon_e.hi);
            check("we_cycle", cyc, mon_e.cyc);
         end
      end
   end

   // Presents a divide in EX starting at the next cycle; startE stays high
   task automatic start_div(input bit sg, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] eh, input logic [31:0] el, input bit push);
      exp_t e;
      @(posedge clk);
      #1;
      bus.startE  = 1'b1;
      bus.signedE = sg;
      bus.srcaE   = a;
      bus.srcbE   = b;
      if (push) begin
         e.hi  = eh;
         e.lo  = el;
         e.cyc = cyc + 33;
         sb.push_back(e);
      end
   endtask

   task automatic finish_div();
      int sc;
      sc = 0;
      for (int i = 0; i < 34; i++) begin
         @(negedge clk);
         if (bus.div_stall) sc++;
      end
      check("stall_cycles", sc, 33);
   endtask

   task automatic go_idle();
      @(posedge clk);
      #1;
      bus.startE = 1'b0;
   endtask

   initial begin
      repeat (3000) @(posedge clk);
      $display("FAIL watchdog cycle=%0d", cyc);
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n       = 1'b0;
      bus.startE  = 1'b0;
      bus.signedE = 1'b0;
      bus.srcaE   = '0;
      bus.srcbE   = '0;
      bus.flushE  = 1'b0;
      #1;
      check("rst_hi", bus.hi_o, 32'h0);
      check("rst_lo", bus.lo_o, 32'h0);
      check("rst_we", {31'b0, bus.hilo_we}, 32'h0);
      check("rst_busy", {31'b0, bus.busy}, 32'h0);
      check("rst_stall", {31'b0, bus.div_stall}, 32'h0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      start_div(1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1);
      finish_div();
      go_idle();
      repeat (3) @(negedge clk);
      check("hold_lo", bus.lo_o, 32'd14);
      check("hold_hi", bus.hi_o, 32'd2);

      // back-to-back: second divide accepted the cycle after DONE
      start_div(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1);
      finish_div();
      start_div(1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b1);
      finish_div();
      start_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b1);
      finish_div();
      start_div(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd14, 1'b1);
      finish_div();
      start_div(1'b1, 32'hFFFF_FFF8, 32'd0, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b1);
      finish_div();
      start_div(1'b0, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'hFFFF_FFFF, 1'b1);
      finish_div();
      go_idle();

      // flush at BUSY iteration 10
      start_div(1'b0, 32'd100, 32'd7, 32'd0, 32'd0, 1'b0);
      repeat (11) @(posedge clk);
      #1;
      bus.flushE = 1'b1;
      bus.startE = 1'b0;
      @(negedge clk);
      check("flush_stall", {31'b0, bus.div_stall}, 32'h0);
      check("flush_busy_pre", {31'b0, bus.busy}, 32'h1);
      @(posedge clk);
      #1 bus.flushE = 1'b0;
      @(negedge clk);
      check("flush_busy_post", {31'b0, bus.busy}, 32'h0);
      start_div(1'b0, 32'd9, 32'd3, 32'd0, 32'd3, 1'b1);
      finish_div();
      go_idle();

      // flush together with startE in IDLE: nothing starts
      @(posedge clk);
      #1;
      bus.startE = 1'b1;
      bus.flushE = 1'b1;
      @(negedge clk);
      check("idle_flush_stall", {31'b0, bus.div_stall}, 32'h0);
      @(posedge clk);
      #1;
      bus.startE = 1'b0;
      bus.flushE = 1'b0;
      @(negedge clk);
      check("idle_flush_busy", {31'b0, bus.busy}, 32'h0);

      // flush in DONE suppresses the write
      start_div(1'b0, 32'd50, 32'd5, 32'd0, 32'd0, 1'b0);
      repeat (33) @(posedge clk);
      #1 bus.flushE = 1'b1;
      @(negedge clk);
      check("done_flush_we", {31'b0, bus.hilo_we}, 32'h0);
      check("done_flush_stall", {31'b0, bus.div_stall}, 32'h0);
      @(posedge clk);
      #1;
      bus.flushE = 1'b0;
      bus.startE = 1'b0;
      @(negedge clk);
      check("done_flush_busy", {31'b0, bus.busy}, 32'h0);

      // async reset at iteration 20
      start_div(1'b0, 32'd1000, 32'd3, 32'd0, 32'd0, 1'b0);
      repeat (21) @(posedge clk);
      #1;
      rst_n      = 1'b0;
      bus.startE = 1'b0;
      #1;
      check("arst_lo", bus.lo_o, 32'h0);
      check("arst_hi", bus.hi_o, 32'h0);
      check("arst_busy", {31'b0, bus.busy}, 32'h0);
      check("arst_we", {31'b0, bus.hilo_we}, 32'h0);
      check("arst_stall", {31'b0, bus.div_stall}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      start_div(1'b0, 32'h1234, 32'd0, 32'h1234, 32'hFFFF_FFFF, 1'b1);
      finish_div();
      go_idle();

      repeat (5) @(posedge clk);
      check("sb_drain", sb.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/div_ctrl.md
# div_ctrl

Sequencing controller for the iterative DIV/DIVU unit in the EX stage. It accepts a divide from EX, holds the front of the pipeline with a stall while it runs a fixed 32-iteration restoring division, then writes the HI/LO result once and releases the stall. An EX flush annuls any divide in flight.

## Interface
Parameters:
- WIDTH, 32, operand/result width; the iteration count equals WIDTH.

Ports (clock and reset: one clock; reset is asynchronous and active-low):
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- startE  in  1  a valid DIV/DIVU is in EX this cycle
- signedE  in  1  1 = DIV (two's complement), 0 = DIVU
- srcaE  in  WIDTH  dividend (rs)
- srcbE  in  WIDTH  divisor (rt)
- flushE  in  1  annul the EX instruction and any divide in flight
- div_stall  out  WIDTH-independent 1  stall request for the F/D/E pipeline registers
- busy  out  1  state is BUSY
- hilo_we  out  1  one-cycle HI/LO write strobe
- hi_o  out  WIDTH  remainder
- lo_o  out  WIDTH  quotient

## Operation
- FSM states: IDLE, BUSY, DONE. Reset: IDLE, iteration counter 0, internal registers 0; hi_o=0, lo_o=0, hilo_we=0, busy=0, div_stall=0.
- IDLE: if startE & ~flushE, latch magnitudes |srcaE|, |srcbE| (signed) or raw values (unsigned), latch the quotient sign (sign(a)^sign(b)), the remainder sign (sign(a)), and whether the divisor is zero. Clear the partial remainder, clear the counter, and go to BUSY.
- BUSY: each cycle performs one restoring step (shift {rem,quo} left, trial-subtract the divisor, keep the result if it is non-negative, set the quotient bit). The counter increments. After the step with counter==WIDTH-1, go to DONE.
- DONE: apply sign fix-up (negate quotient if the quotient sign is set, negate remainder if the remainder sign is set). Drive hi_o/lo_o and pulse hilo_we=1 for exactly this cycle, then go to IDLE unconditionally. startE is ignored in DONE because the same instruction is still in EX.
- Divide by zero: lo_o = all ones, hi_o = the original srcaE (unsigned and signed alike). Timing is unchanged.
- Signed overflow: 0x80000000 / -1 gives lo_o=0x80000000, hi_o=0.
- hi_o/lo_o hold their last value outside DONE.
- flushE in BUSY: next state is IDLE, no hilo_we. flushE in DONE: hilo_we is suppressed (0). flushE in IDLE with startE: no start.

## Timing
- div_stall = ((IDLE & startE) | BUSY) & ~flushE, combinational. Startup therefore stalls in the same cycle the divide appears in EX.
- Startup at edge t (startE sampled in IDLE in cycle t): BUSY spans cycles t+1..t+WIDTH, DONE is cycle t+WIDTH+1. div_stall is high in cycles t..t+WIDTH (33 cycles for WIDTH=32) and low in DONE, so the divide leaves EX at the end of DONE together with hilo_we.
- Back-to-back divides: the next startE is accepted in IDLE on the cycle after DONE.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0; no write.

## Structure
- Shared package: state encoding constants (IDLE/BUSY/DONE) and the DIV_ITERS constant (=32).
- One sub-module, div_step: a purely combinational single restoring iteration (rem, quo, divisor -> next rem, next quo). It is instantiated once.
- The top level holds the FSM, the counter ($clog2(WIDTH)+1 bits), operand and sign latches, and fix-up negation.

## Test plan
- DIVU 100/7 started at cycle 0: div_stall high for cycles 0..32, hilo_we at cycle 33 with lo_o=14, hi_o=2.
- DIV -7/2 (0xFFFFFFF9, 2): lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF. DIV 7/-2: lo_o=0xFFFFFFFD, hi_o=1.
- DIV 0x80000000/0xFFFFFFFF: lo_o=0x80000000, hi_o=0. DIVU 0x1234/0: lo_o=0xFFFFFFFF, hi_o=0x1234 at cycle 33.
- flushE at BUSY iteration 10: IDLE next cycle, div_stall drops with the flush, no hilo_we. DIVU 9/3 started the following cycle: lo_o=3, hi_o=0 after 33 cycles.
- startE held high through DONE: exactly one hilo_we, FSM in IDLE afterwards. A new startE one cycle later starts a second divide.
- rst_n pulsed low at iteration 20: outputs 0 asynchronously, state IDLE, no hilo_we, next divide runs normally.
